rgb_lut_arbiter: RTL and testbench

RGB_LUT_ARBITER -- requirements
Module: rgb_lut_arbiter

---
 rtl/rgb_lut_arbiter.sv | 101 ++++++++++
 tb/tb_rgb_lut_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_lut_arbiter.sv
// rtl/rgb_lut_arbiter.sv - round-robin arbiter sharing one palette ROM between two lookup requesters
// A single response register is refilled in the same cycle it is consumed, so lookups sustain one per cycle.
module rgb_lut_arbiter #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_index,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_index,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [3:0]       rom_address,
    input  logic [23:0]      rom_data_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [23:0]      rsp_rgb,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      rsp_count
);

    logic             rsp_valid_q, rsp_valid_d;
    logic [23:0]      rsp_rgb_q, rsp_rgb_d;
    logic             rsp_src_q, rsp_src_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [15:0]      rsp_count_q, rsp_count_d;
    logic             last_grant_q, last_grant_d;

    logic slot_free;
    logic any_valid;
    logic cand;
    logic accept;

    always_comb begin
        slot_free = !rsp_valid_q || rsp_ready;
        any_valid = req0_valid || req1_valid;
        // Under contention the requester that did not win last time goes next.
        if (req0_valid && req1_valid) begin
            cand = !last_grant_q;
        end else begin
            cand = req1_valid;
        end
        accept = slot_free && any_valid;

        rom_address = 4'h0;
        if (any_valid) begin
            rom_address = cand ? req1_index : req0_index;
        end
        req0_ready = accept && !cand;
        req1_ready = accept && cand;

        rsp_valid_d  = rsp_valid_q;
        rsp_rgb_d    = rsp_rgb_q;
        rsp_src_d    = rsp_src_q;
        rsp_tag_d    = rsp_tag_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_rgb_d    = rom_data_q;
            rsp_src_d    = cand;
            rsp_tag_d    = cand ? req1_tag : req0_tag;
            last_grant_d = cand;
        end else if (slot_free) begin
            rsp_valid_d = 1'b0;
        end

        rsp_count_d = rsp_count_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_count_d = rsp_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_rgb_q    <= 24'h0;
            rsp_src_q    <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_count_q  <= 16'h0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_rgb_q    <= rsp_rgb_d;
            rsp_src_q    <= rsp_src_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_count_q  <= rsp_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rgb   = rsp_rgb_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_rgb_lut_arbiter.sv
// tb/tb_rgb_lut_arbiter.sv - self-checking bench for rgb_lut_arbiter
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_rgb_lut_arbiter;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [3:0]       req0_index = 4'h0;
    logic [TAG_W-1:0] req0_tag = '0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [3:0]       req1_index = 4'h0;
    logic [TAG_W-1:0] req1_tag = '0;
    logic [3:0]       rom_address;
    logic [23:0]      rom_data_q;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [23:0]      rsp_rgb;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0]      rsp_count;

    logic [23:0] palette [16];
    assign rom_data_q = palette[rom_address];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rgb_lut_arbiter #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_index (req0_index),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_index (req1_index),
        .req1_tag   (req1_tag),
        .rom_address(rom_address),
        .rom_data_q (rom_data_q),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rgb    (rsp_rgb),
        .rsp_src    (rsp_src),
        .rsp_tag    (rsp_tag),
        .rsp_count  (rsp_count)
    );

    // Transaction-level model: who holds the response slot, what it contains, how many were consumed.
    logic             m_valid;
    logic [23:0]      m_rgb;
    logic             m_src;
    logic [TAG_W-1:0] m_tag;
    logic [15:0]      m_count;
    int               m_last;
    int               m_who;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_rgb   = 24'h0;
            m_src   = 1'b0;
            m_tag   = '0;
            m_count = 16'h0;
            m_last  = 1;
        end else begin
            if (m_valid && rsp_ready) m_count = m_count + 16'd1;
            if (!m_valid || rsp_ready) begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) m_who = 1 - m_last;
                    else m_who = req1_valid ? 1 : 0;
                    m_rgb   = palette[(m_who == 1) ? req1_index : req0_index];
                    m_tag   = (m_who == 1) ? req1_tag : req0_tag;
                    m_src   = (m_who == 1);
                    m_valid = 1'b1;
                    m_last  = m_who;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_rgb !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000000", rsp_rgb); end
        n_checks++; if (rsp_src !== 1'b0) begin n_fail++; $display("FAIL reset_src: got %b expected 0", rsp_src); end
        n_checks++; if (rsp_tag !== 8'h00) begin n_fail++; $display("FAIL reset_tag: got %h expected 00", rsp_tag); end
        n_checks++; if (rsp_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", rsp_count); end
        @(posedge clk);
        #1 rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_index = 4'h3;
        req1_index = 4'hA;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL first_ready0: got %b expected 1", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL first_ready1: got %b expected 0", req1_ready); end
    endtask

    task automatic test_single_lookup();
        do_reset();
        req0_valid = 1'b1;
        req0_index = 4'h3;
        req0_tag   = 8'h11;
        rsp_ready  = 1'b1;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", req0_ready); end
        n_checks++; if (rom_address !== 4'h3) begin n_fail++; $display("FAIL single_addr: got %h expected 3", rom_address); end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rom_address !== 4'h0) begin n_fail++; $display("FAIL idle_addr: got %h expected 0", rom_address); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", rsp_valid); end
        n_checks++; if (rsp_rgb !== 24'hFFA000) begin n_fail++; $display("FAIL single_rgb: got %h expected FFA000", rsp_rgb); end
        n_checks++; if (rsp_src !== 1'b0) begin n_fail++; $display("FAIL single_src: got %b expected 0", rsp_src); end
        n_checks++; if (rsp_tag !== 8'h11) begin n_fail++; $display("FAIL single_tag: got %h expected 11", rsp_tag); end
    endtask

    task automatic test_round_robin();
        logic exp_s;
        logic [23:0] exp_rgb;
        do_reset();
        req0_index = 4'h0;
        req1_index = 4'hA;
        req0_tag   = 8'h01;
        req1_tag   = 8'h02;
        rsp_ready  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req0_valid = (k < 4);
            req1_valid = (k < 4);
            @(negedge clk);
            if (k > 0) begin
                exp_s   = ((k - 1) % 2) == 1;
                exp_rgb = exp_s ? 24'hFF0000 : 24'hA056FF;
                n_checks++; if (rsp_src !== exp_s) begin n_fail++; $display("FAIL rr_src[%0d]: got %b expected %b", k - 1, rsp_src, exp_s); end
                n_checks++; if (rsp_rgb !== exp_rgb) begin n_fail++; $display("FAIL rr_rgb[%0d]: got %h expected %h", k - 1, rsp_rgb, exp_rgb); end
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_checks++; if (rsp_count !== 16'd4) begin n_fail++; $display("FAIL rr_count: got %0d expected 4", rsp_count); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1'b1;
        req0_index = 4'h3;
        req0_tag   = 8'h22;
        rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        req1_valid = 1'b1;
        req1_index = 4'hA;
        req1_tag   = 8'h33;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", k, req1_ready); end
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, rsp_valid); end
            n_checks++; if (rsp_rgb !== 24'hFFA000) begin n_fail++; $display("FAIL bp_rgb[%0d]: got %h expected FFA000", k, rsp_rgb); end
            n_checks++; if (rsp_tag !== 8'h22) begin n_fail++; $display("FAIL bp_tag[%0d]: got %h expected 22", k, rsp_tag); end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", req1_ready); end
        @(posedge clk);
        #1 req1_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_rgb !== 24'hFF0000) begin n_fail++; $display("FAIL b2b_rgb: got %h expected FF0000", rsp_rgb); end
        n_checks++; if (rsp_src !== 1'b1) begin n_fail++; $display("FAIL b2b_src: got %b expected 1", rsp_src); end
        n_checks++; if (rsp_tag !== 8'h33) begin n_fail++; $display("FAIL b2b_tag: got %h expected 33", rsp_tag); end
        n_checks++; if (rsp_count !== 16'd1) begin n_fail++; $display("FAIL b2b_count: got %0d expected 1", rsp_count); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        req0_valid = 1'b1;
        req0_index = 4'h3;
        rsp_ready  = 1'b1;
        repeat (65536) @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %h expected FFFF", rsp_count); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (rsp_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", rsp_count); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_valid: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_index = 4'h0;
        req1_index = 4'hA;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (rsp_count !== 16'd2) begin n_fail++; $display("FAIL ar_pre_count: got %0d expected 2", rsp_count); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_count !== 16'h0) begin n_fail++; $display("FAIL ar_count: got %h expected 0000", rsp_count); end
        n_checks++; if (rsp_rgb !== 24'h0) begin n_fail++; $display("FAIL ar_rgb: got %h expected 000000", rsp_rgb); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready0: got %b expected 1", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL ar_ready1: got %b expected 0", req1_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (rsp_src !== 1'b0) begin n_fail++; $display("FAIL ar_src: got %b expected 0", rsp_src); end
        n_checks++; if (rsp_rgb !== 24'hA056FF) begin n_fail++; $display("FAIL ar_first_rgb: got %h expected A056FF", rsp_rgb); end
    endtask

    task automatic test_random_traffic();
        logic       e_free;
        int         e_who;
        logic       e_r0, e_r1;
        logic [3:0] e_addr;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req0_valid = ($urandom_range(2, 0) != 0);
            req1_valid = ($urandom_range(2, 0) != 0);
            req0_index = 4'($urandom_range(15, 0));
            req1_index = 4'($urandom_range(15, 0));
            req0_tag   = 8'($urandom_range(255, 0));
            req1_tag   = 8'($urandom_range(255, 0));
            rsp_ready  = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            e_free = !m_valid || rsp_ready;
            if (req0_valid && req1_valid) e_who = 1 - m_last;
            else e_who = req1_valid ? 1 : 0;
            e_r0   = e_free && req0_valid && (e_who == 0);
            e_r1   = e_free && req1_valid && (e_who == 1);
            e_addr = !(req0_valid || req1_valid) ? 4'h0 : ((e_who == 1) ? req1_index : req0_index);
            n_checks++; if (req0_ready !== e_r0) begin n_fail++; $display("FAIL rnd_ready0 @%0d: got %b expected %b", c, req0_ready, e_r0); end
            n_checks++; if (req1_ready !== e_r1) begin n_fail++; $display("FAIL rnd_ready1 @%0d: got %b expected %b", c, req1_ready, e_r1); end
            n_checks++; if (rom_address !== e_addr) begin n_fail++; $display("FAIL rnd_addr @%0d: got %h expected %h", c, rom_address, e_addr); end
            n_checks++; if (rsp_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b expected %b", c, rsp_valid, m_valid); end
            n_checks++; if (rsp_rgb !== m_rgb) begin n_fail++; $display("FAIL rnd_rgb @%0d: got %h expected %h", c, rsp_rgb, m_rgb); end
            n_checks++; if (rsp_src !== m_src) begin n_fail++; $display("FAIL rnd_src @%0d: got %b expected %b", c, rsp_src, m_src); end
            n_checks++; if (rsp_tag !== m_tag) begin n_fail++; $display("FAIL rnd_tag @%0d: got %h expected %h", c, rsp_tag, m_tag); end
            n_checks++; if (rsp_count !== m_count) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d expected %0d", c, rsp_count, m_count); end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) palette[i] = 24'($urandom);
        palette[0]  = 24'hA056FF;
        palette[3]  = 24'hFFA000;
        palette[10] = 24'hFF0000;
        test_reset();
        test_single_lookup();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        test_random_traffic();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
